bf_stdout_uart_tx: RTL and testbench
====================================

Name: bf_stdout_uart_tx

Overview:
Downstream consumer of the brainfuck core's stdout byte strobe. Buffers output bytes in a small FIFO and serializes them as 8N1 UART frames, LSB first, on the board TX pin. Applies backpressure to the core through in_ready so bursts of "." instructions are never silently dropped while in_ready is honoured.

Parameters:
BAUD_DIV, 104, clk cycles per UART bit; legal range 1..65535; 1 gives the fastest frames for simulation.
FIFO_DEPTH, 16, FIFO entries; power of two, minimum 2.
ADDR_W, $clog2(FIFO_DEPTH), FIFO pointer width; derived, not overridden.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_data  in  8  stdout byte from the core.
in_valid  in  1  in_data valid; single-cycle strobe or held.
in_ready  out  1  FIFO can accept a byte this cycle.
uart_tx_pin  out  1  serial output, idle high.
busy  out  1  high while a frame is in progress or the FIFO is non-empty.
overflow  out  1  sticky flag: a write was attempted while in_ready was low.
fifo_level  out  ADDR_W+1  current FIFO occupancy, 0..FIFO_DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): uart_tx_pin=1, in_ready=1, busy=0, overflow=0, fifo_level=0, FSM=IDLE, baud counter=0. Asserting rst_n mid-frame forces uart_tx_pin high immediately, with no partial completion of the frame. Release is synchronous to clk.
- Push: on a clk edge with in_valid && in_ready, in_data is written and fifo_level increments.
- in_ready is registered and is 0 iff fifo_level==FIFO_DEPTH. A pop in the same cycle does not make a full FIFO accept a write.
- in_valid && !in_ready: the byte is discarded and overflow is set until reset.
- Simultaneous push and pop with the FIFO not full: fifo_level is unchanged and data order is preserved. Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, START, DATA, STOP (plus PARITY when the optional feature is enabled).
  - IDLE: if the FIFO is non-empty, pop the head into the shift register, load the baud counter with BAUD_DIV-1, drive tx=0, and enter START.
  - START: hold for BAUD_DIV cycles, then enter DATA with bit index 0.
  - DATA: drive shift[0] for BAUD_DIV cycles per bit, shifting right; after bit 7, enter STOP.
  - STOP: drive tx=1 for BAUD_DIV cycles. At the end of STOP:
    - if the FIFO is non-empty, pop and go directly to START, with no extra idle cycles;
    - otherwise go to IDLE.
- Latency: a byte pushed into an empty FIFO while in IDLE produces the tx falling edge registered at the 2nd clk edge after the accepting edge.
- Frame length is exactly 10*BAUD_DIV clk cycles. Back-to-back frames are contiguous.
- Baud counter: 16-bit down-counter; a bit boundary occurs when the counter reaches 0, then it reloads BAUD_DIV-1. BAUD_DIV=1 gives one cycle per bit.
- busy = (FSM != IDLE) || (fifo_level != 0). All outputs are registered except busy.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: a PARITY state is inserted between DATA and STOP and drives the even-parity bit (XOR of the 8 data bits) for BAUD_DIV cycles. Frame length becomes 11*BAUD_DIV.
- Undefined: no PARITY state, no parity logic; 8N1 frames of 10*BAUD_DIV cycles.

Test Plan:
- Reset checks: hold rst_n low for 3 cycles with in_valid toggling -> uart_tx_pin=1, in_ready=1, busy=0, overflow=0, fifo_level=0 throughout; no writes are accepted.
- Single byte, BAUD_DIV=4: push 0x48 once -> tx goes low 2 edges later. Bits over 40 cycles: 0, then 0,0,0,1,0,0,1,0, then 1. busy falls after the stop bit.
- Back-to-back, BAUD_DIV=1: push 0x48 then 0x69 on consecutive cycles -> two contiguous 10-cycle frames, the second start bit immediately after the first stop bit. fifo_level sequence is 1,1,0.
- Full and overflow, FIFO_DEPTH=4, BAUD_DIV=8: push 6 bytes on consecutive cycles.
  - The first byte is popped on the edge after its push.
  - in_ready drops once fifo_level=4.
  - The 6th byte is discarded and overflow=1.
  - Exactly 5 frames are transmitted, in order.
- Reset mid-frame, BAUD_DIV=4: assert rst_n during data bit 3 -> tx=1 asynchronously, FIFO emptied. After release, a new push 0x55 transmits cleanly.
- With UART_TX_PARITY_EN, BAUD_DIV=2: push 0x07 -> the parity bit is 1 and the frame is 22 cycles. Push 0x03 -> the parity bit is 0.

Source files
------------

// File: rtl/bf_stdout_uart_tx.sv
// bf_stdout_uart_tx: stdout byte buffer and UART serializer for the brainfuck core.
// Bytes strobed in on in_valid/in_ready land in a FIFO. They leave as 8N1 frames,
// LSB first, on uart_tx_pin.
// Optional feature macro: UART_TX_PARITY_EN. When it is defined, an even-parity bit is
// inserted between the data bits and the stop bit, giving 11-bit frames.
module bf_stdout_uart_tx #(
  parameter int BAUD_DIV   = 104,
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = $clog2(FIFO_DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      in_data,
  input  logic            in_valid,
  output logic            in_ready,
  output logic            uart_tx_pin,
  output logic            busy,
  output logic            overflow,
  output logic [ADDR_W:0] fifo_level
);

  localparam logic [15:0]       BAUD_RELOAD = 16'(BAUD_DIV - 1);
  localparam logic [ADDR_W:0]   FULL_LEVEL  = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   LEVEL_ONE   = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   LEVEL_ZERO  = {(ADDR_W + 1){1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ZERO    = {ADDR_W{1'b0}};

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // Even parity: the bit makes the total count of ones in data plus parity even.
  function automatic logic even_parity(input logic [7:0] d);
    return ^d;
  endfunction
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_e;
`endif

  logic [7:0]        mem_q [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   level_q, level_d;
  logic              in_ready_q;
  logic              overflow_q;
  state_e            state_q;
  logic [15:0]       cnt_q;
  logic [2:0]        bit_idx_q;
  logic [7:0]        shift_q;
  logic              tx_q;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
`endif

  logic              push_s;
  logic              pop_s;
  logic              bit_end_s;
  logic [7:0]        head_s;

  // Handshake, pop decision and next FIFO occupancy.
  // The frame engine pops from IDLE, or at the last cycle of STOP, so frames run back to back.
  always_comb begin
    push_s    = in_valid && in_ready_q;
    bit_end_s = (cnt_q == 16'd0);
    head_s    = mem_q[rd_ptr_q];
    pop_s     = (level_q != LEVEL_ZERO) &&
                ((state_q == S_IDLE) || ((state_q == S_STOP) && bit_end_s));
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  // FIFO storage. The contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers, occupancy, registered ready, and the sticky overflow flag.
  // Ready looks only at the next level, so a pop cannot open a slot for a write in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= PTR_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      level_q    <= LEVEL_ZERO;
      in_ready_q <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      level_q    <= level_d;
      in_ready_q <= (level_d != FULL_LEVEL);
      overflow_q <= overflow_q | (in_valid & ~in_ready_q);
    end
  end

  // Frame FSM with baud down-counter. The pin register follows the state of the previous cycle,
  // so each bit stays on the pin for exactly BAUD_DIV cycles, one cycle behind the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'd0;
      tx_q      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_START:  tx_q <= 1'b0;
        S_DATA:   tx_q <= shift_q[0];
`ifdef UART_TX_PARITY_EN
        S_PARITY: tx_q <= parity_q;
`endif
        default:  tx_q <= 1'b1;
      endcase

      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            shift_q  <= head_s;
`ifdef UART_TX_PARITY_EN
            parity_q <= even_parity(head_s);
`endif
            cnt_q    <= BAUD_RELOAD;
            state_q  <= S_START;
          end
        end
        S_START: begin
          if (bit_end_s) begin
            cnt_q     <= BAUD_RELOAD;
            bit_idx_q <= 3'd0;
            state_q   <= S_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        S_DATA: begin
          if (bit_end_s) begin
            cnt_q   <= BAUD_RELOAD;
            shift_q <= {1'b0, shift_q[7:1]};
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q <= S_PARITY;
`else
              state_q <= S_STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end_s) begin
            cnt_q   <= BAUD_RELOAD;
            state_q <= S_STOP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (bit_end_s) begin
            if (pop_s) begin
              shift_q  <= head_s;
`ifdef UART_TX_PARITY_EN
              parity_q <= even_parity(head_s);
`endif
              cnt_q    <= BAUD_RELOAD;
              state_q  <= S_START;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign uart_tx_pin = tx_q;
  assign overflow    = overflow_q;
  assign fifo_level  = level_q;
  assign busy        = (state_q != S_IDLE) || (level_q != LEVEL_ZERO);

endmodule

// File: tb/tb_bf_stdout_uart_tx.sv
// tb_bf_stdout_uart_tx: directed bench for bf_stdout_uart_tx.
// Several instances with different baud and depth settings share the clock and the reset.
`timescale 1ns/1ps
module tb_bf_stdout_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  // u_b4: BAUD_DIV=4, depth 16
  logic [7:0] a_data = 8'h00;
  logic       a_valid = 1'b0;
  logic       a_ready, a_tx, a_busy, a_ovf;
  logic [4:0] a_level;
  // u_b1: BAUD_DIV=1, depth 16
  logic [7:0] b_data = 8'h00;
  logic       b_valid = 1'b0;
  logic       b_ready, b_tx, b_busy, b_ovf;
  logic [4:0] b_level;
  // u_f4: BAUD_DIV=8, depth 4
  logic [7:0] f_data = 8'h00;
  logic       f_valid = 1'b0;
  logic       f_ready, f_tx, f_busy, f_ovf;
  logic [2:0] f_level;

  bf_stdout_uart_tx #(.BAUD_DIV(4), .FIFO_DEPTH(16)) u_b4 (
    .clk(clk), .rst_n(rst_n), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .uart_tx_pin(a_tx), .busy(a_busy), .overflow(a_ovf), .fifo_level(a_level));
  bf_stdout_uart_tx #(.BAUD_DIV(1), .FIFO_DEPTH(16)) u_b1 (
    .clk(clk), .rst_n(rst_n), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .uart_tx_pin(b_tx), .busy(b_busy), .overflow(b_ovf), .fifo_level(b_level));
  bf_stdout_uart_tx #(.BAUD_DIV(8), .FIFO_DEPTH(4)) u_f4 (
    .clk(clk), .rst_n(rst_n), .in_data(f_data), .in_valid(f_valid), .in_ready(f_ready),
    .uart_tx_pin(f_tx), .busy(f_busy), .overflow(f_ovf), .fifo_level(f_level));

`ifdef UART_TX_PARITY_EN
  // u_b2: BAUD_DIV=2, depth 16, parity frames
  logic [7:0] p_data = 8'h00;
  logic       p_valid = 1'b0;
  logic       p_ready, p_tx, p_busy, p_ovf;
  logic [4:0] p_level;
  bf_stdout_uart_tx #(.BAUD_DIV(2), .FIFO_DEPTH(16)) u_b2 (
    .clk(clk), .rst_n(rst_n), .in_data(p_data), .in_valid(p_valid), .in_ready(p_ready),
    .uart_tx_pin(p_tx), .busy(p_busy), .overflow(p_ovf), .fifo_level(p_level));
`endif

  // Expected line level for bit slot j of a frame carrying byte b
  function automatic logic exp_bit(input logic [7:0] b, input int j);
    if (j == 0) return 1'b0;
    if (j <= 8) return b[j-1];
    if (FB == 11 && j == 9) return ^b;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_valid = (i % 2 == 0); b_valid = (i % 2 == 0); f_valid = (i % 2 == 0);
      a_data = 8'h5A; b_data = 8'h5A; f_data = 8'h5A;
      tick();
      n_cmp++;
      if (a_tx !== 1'b1 || a_ready !== 1'b1 || a_busy !== 1'b0 || a_ovf !== 1'b0 || a_level !== 5'd0) begin
        n_err++;
        $display("FAIL reset_b4 cyc%0d: tx=%b ready=%b busy=%b ovf=%b level=%0d, required 1 1 0 0 0",
                 i, a_tx, a_ready, a_busy, a_ovf, a_level);
      end
      n_cmp++;
      if (f_tx !== 1'b1 || f_ready !== 1'b1 || f_busy !== 1'b0 || f_ovf !== 1'b0 || f_level !== 3'd0) begin
        n_err++;
        $display("FAIL reset_f4 cyc%0d: tx=%b ready=%b busy=%b ovf=%b level=%0d, required 1 1 0 0 0",
                 i, f_tx, f_ready, f_busy, f_ovf, f_level);
      end
    end
    a_valid = 1'b0; b_valid = 1'b0; f_valid = 1'b0;
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (a_level !== 5'd0 || a_busy !== 1'b0 || b_level !== 5'd0 || a_tx !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release: a_level=%0d a_busy=%b b_level=%0d a_tx=%b, required 0 0 0 1",
               a_level, a_busy, b_level, a_tx);
    end
  endtask

  task automatic test_single_byte();
    a_data = 8'h48; a_valid = 1'b1;
    tick();                                  // accepting edge
    a_valid = 1'b0;
    n_cmp++;
    if (a_level !== 5'd1 || a_tx !== 1'b1) begin
      n_err++;
      $display("FAIL single_accept: level=%0d tx=%b, required 1 1", a_level, a_tx);
    end
    tick();
    n_cmp++;
    if (a_tx !== 1'b1) begin
      n_err++;
      $display("FAIL single_edge1: tx=%b, required 1", a_tx);
    end
    tick();                                  // second edge: start bit on pin
    for (int k = 0; k < FB * 4; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if (a_tx !== exp_bit(8'h48, k / 4)) begin
        n_err++;
        $display("FAIL single_bit k=%0d: tx=%b, required %b", k, a_tx, exp_bit(8'h48, k / 4));
      end
      if (k == FB * 4 - 2) begin
        n_cmp++;
        if (a_busy !== 1'b1) begin
          n_err++;
          $display("FAIL single_busy_stop: busy=%b, required 1", a_busy);
        end
      end
    end
    tick();
    n_cmp++;
    if (a_busy !== 1'b0 || a_tx !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: busy=%b tx=%b, required 0 1", a_busy, a_tx);
    end
  endtask

  task automatic test_back_to_back();
    b_data = 8'h48; b_valid = 1'b1;
    tick();
    n_cmp++;
    if (b_level !== 5'd1) begin
      n_err++;
      $display("FAIL b2b_level0: level=%0d, required 1", b_level);
    end
    b_data = 8'h69;
    tick();
    b_valid = 1'b0;
    n_cmp++;
    if (b_level !== 5'd1) begin
      n_err++;
      $display("FAIL b2b_level1: level=%0d, required 1", b_level);
    end
    tick();
    for (int k = 0; k < 2 * FB; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if (b_tx !== ((k < FB) ? exp_bit(8'h48, k) : exp_bit(8'h69, k - FB))) begin
        n_err++;
        $display("FAIL b2b_bit k=%0d: tx=%b, required %b", k, b_tx,
                 (k < FB) ? exp_bit(8'h48, k) : exp_bit(8'h69, k - FB));
      end
      if (k == FB - 2 || k == FB - 1) begin
        n_cmp++;
        if (b_level !== ((k == FB - 2) ? 5'd1 : 5'd0)) begin
          n_err++;
          $display("FAIL b2b_level k=%0d: level=%0d, required %0d", k, b_level, (k == FB - 2) ? 1 : 0);
        end
      end
    end
    tick();
    n_cmp++;
    if (b_busy !== 1'b0 || b_tx !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_done: busy=%b tx=%b, required 0 1", b_busy, b_tx);
    end
  endtask

  task automatic test_full_overflow();
    logic [7:0] bytes [6];
    logic [2:0] exp_lvl [6];
    logic       exp_rdy [6];
    logic       exp_ovf [6];
    int         s;
    logic       e;
    bytes   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_lvl = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4};
    exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    exp_ovf = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    f_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      f_data = bytes[i];
      tick();
      n_cmp++;
      if (f_level !== exp_lvl[i] || f_ready !== exp_rdy[i] || f_ovf !== exp_ovf[i]) begin
        n_err++;
        $display("FAIL full_push%0d: level=%0d ready=%b ovf=%b, required %0d %b %b",
                 i, f_level, f_ready, f_ovf, exp_lvl[i], exp_rdy[i], exp_ovf[i]);
      end
      e = (i < 2) ? 1'b1 : exp_bit(bytes[0], (i - 2) / 8);
      n_cmp++;
      if (f_tx !== e) begin
        n_err++;
        $display("FAIL full_tx_early%0d: tx=%b, required %b", i, f_tx, e);
      end
    end
    f_valid = 1'b0;
    for (s = 4; s < 5 * FB * 8; s++) begin
      tick();
      e = exp_bit(bytes[s / (FB * 8)], (s % (FB * 8)) / 8);
      n_cmp++;
      if (f_tx !== e) begin
        n_err++;
        $display("FAIL full_tx s=%0d frame=%0d: tx=%b, required %b", s, s / (FB * 8), f_tx, e);
      end
    end
    tick();
    n_cmp++;
    if (f_tx !== 1'b1 || f_busy !== 1'b0 || f_level !== 3'd0 || f_ovf !== 1'b1 || f_ready !== 1'b1) begin
      n_err++;
      $display("FAIL full_done: tx=%b busy=%b level=%0d ovf=%b ready=%b, required 1 0 0 1 1",
               f_tx, f_busy, f_level, f_ovf, f_ready);
    end
  endtask

  task automatic test_reset_mid_frame();
    a_data = 8'hA5; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    tick();                                  // k=0: start bit
    for (int k = 1; k <= 17; k++) tick();    // k=17: data bit 3 (0 for 0xA5)
    n_cmp++;
    if (a_tx !== 1'b0 || a_busy !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pre: tx=%b busy=%b, required 0 1", a_tx, a_busy);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (a_tx !== 1'b1 || a_level !== 5'd0 || a_busy !== 1'b0 || f_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async: tx=%b level=%0d busy=%b f_ovf=%b, required 1 0 0 0",
               a_tx, a_level, a_busy, f_ovf);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++;
    if (a_tx !== 1'b1 || a_busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_release: tx=%b busy=%b, required 1 0", a_tx, a_busy);
    end
    a_data = 8'h55; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < FB * 4; k++) begin
      if (k > 0) tick();
      n_cmp++;
      if (a_tx !== exp_bit(8'h55, k / 4)) begin
        n_err++;
        $display("FAIL mid_new_bit k=%0d: tx=%b, required %b", k, a_tx, exp_bit(8'h55, k / 4));
      end
    end
    tick();
    n_cmp++;
    if (a_busy !== 1'b0 || a_tx !== 1'b1) begin
      n_err++;
      $display("FAIL mid_new_done: busy=%b tx=%b, required 0 1", a_busy, a_tx);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] pb [2];
    logic       pbit [2];
    pb   = '{8'h07, 8'h03};
    pbit = '{1'b1, 1'b0};
    for (int f = 0; f < 2; f++) begin
      p_data = pb[f]; p_valid = 1'b1;
      tick();
      p_valid = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 22; k++) begin
        if (k > 0) tick();
        n_cmp++;
        if (p_tx !== exp_bit(pb[f], k / 2)) begin
          n_err++;
          $display("FAIL parity_bit byte=%h k=%0d: tx=%b, required %b", pb[f], k, p_tx, exp_bit(pb[f], k / 2));
        end
        if (k == 18) begin
          n_cmp++;
          if (p_tx !== pbit[f]) begin
            n_err++;
            $display("FAIL parity_value byte=%h: tx=%b, required %b", pb[f], p_tx, pbit[f]);
          end
        end
      end
      tick();
      n_cmp++;
      if (p_busy !== 1'b0 || p_tx !== 1'b1) begin
        n_err++;
        $display("FAIL parity_done byte=%h: busy=%b tx=%b, required 0 1", pb[f], p_busy, p_tx);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_full_overflow();
    test_reset_mid_frame();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
